// File: rtl/pixel_packer_w128.sv
// Repacks 8 x 12-bit pixel beats (96 bits) into dense 128-bit FIFO words,
// with line/frame bookkeeping and sticky overflow on FIFO back-pressure.
module pixel_packer_w128 (
  input  logic          clk_rxg,
  input  logic          rst_rx,
  input  logic [11:0]   datapar_in0,
  input  logic [11:0]   datapar_in1,
  input  logic [11:0]   datapar_in2,
  input  logic [11:0]   datapar_in3,
  input  logic [11:0]   datapar_in4,
  input  logic [11:0]   datapar_in5,
  input  logic [11:0]   datapar_in6,
  input  logic [11:0]   datapar_in7,
  input  logic          fvals,
  input  logic          lvals,
  input  logic          fifo_full,
  output logic [127:0]  fifo_din,
  output logic          fifo_wr_en,
  output logic          sof,
  output logic          line_end,
  output logic [11:0]   line_cnt,
  output logic [15:0]   frame_cnt,
  output logic          ovf
);

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  logic [95:0]  beat_p0;
  logic         acc_p0;
  logic         acc_d;
  logic         fvals_d;
  logic         frame_start_p0;
  logic         line_stop_p0;
  logic [1:0]   phase;
  logic [1:0]   phase_nxt;
  logic [95:0]  resid;
  logic [95:0]  resid_nxt;
  logic [127:0] word_p0;
  logic         due_p0;
  logic         sof_pend;

  assign beat_p0 = {datapar_in7, datapar_in6, datapar_in5, datapar_in4,
                    datapar_in3, datapar_in2, datapar_in1, datapar_in0};
  assign acc_p0         = fvals & lvals;
  assign frame_start_p0 = fvals & ~fvals_d;
  assign line_stop_p0   = acc_d & ~acc_p0;

  // Stage p0: gearbox. The residual is kept zero-extended so a flush word
  // is simply the residual with zeros above.
  always_comb begin
    phase_nxt = phase;
    resid_nxt = resid;
    word_p0   = '0;
    due_p0    = 1'b0;
    if (acc_p0) begin
      case (phase)
        2'd0: begin
          resid_nxt = beat_p0;
          phase_nxt = 2'd1;
        end
        2'd1: begin
          word_p0   = {beat_p0[31:0], resid};
          resid_nxt = {32'b0, beat_p0[95:32]};
          phase_nxt = 2'd2;
          due_p0    = 1'b1;
        end
        2'd2: begin
          word_p0   = {beat_p0[63:0], resid[63:0]};
          resid_nxt = {64'b0, beat_p0[95:64]};
          phase_nxt = 2'd3;
          due_p0    = 1'b1;
        end
        2'd3: begin
          word_p0   = {beat_p0, resid[31:0]};
          resid_nxt = '0;
          phase_nxt = 2'd0;
          due_p0    = 1'b1;
        end
      endcase
    end else if (line_stop_p0) begin
      word_p0   = {32'b0, resid};
      due_p0    = (phase != 2'd0);
      resid_nxt = '0;
      phase_nxt = 2'd0;
    end
  end

  // Stage p1: registered word, strobes and bookkeeping.
  always_ff @(posedge clk_rxg) begin
    if (rst_rx) begin
      acc_d      <= 1'b0;
      fvals_d    <= 1'b0;
      phase      <= 2'd0;
      resid      <= '0;
      sof_pend   <= 1'b0;
      fifo_din   <= '0;
      fifo_wr_en <= 1'b0;
      sof        <= 1'b0;
      line_end   <= 1'b0;
      line_cnt   <= '0;
      frame_cnt  <= '0;
      ovf        <= 1'b0;
    end else begin
      acc_d      <= acc_p0;
      fvals_d    <= fvals;
      phase      <= phase_nxt;
      resid      <= resid_nxt;
      line_end   <= line_stop_p0;
      fifo_wr_en <= due_p0 & ~fifo_full;
      sof        <= due_p0 & ~fifo_full & (sof_pend | frame_start_p0);
      if (due_p0 && !fifo_full)
        fifo_din <= word_p0;
      if (frame_start_p0) begin
        frame_cnt <= frame_cnt + 16'd1;
        line_cnt  <= '0;
        ovf       <= 1'b0;
        sof_pend  <= 1'b1;
      end else if (line_stop_p0) begin
        line_cnt <= sat_inc12(line_cnt);
      end
      // A dropped word still consumes the pending start-of-frame marker.
      if (due_p0) begin
        sof_pend <= 1'b0;
        if (fifo_full)
          ovf <= 1'b1;
      end
    end
  end

endmodule
